// File: rtl/ram_arbiter.sv
// Two-requester arbiter and sequencer for the shared multi-cycle 256x8 RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ram_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_SMP = 3,
  parameter int RD_OCC = 5,
  parameter int WR_OCC = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_rd_addr,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  input  logic [DW-1:0] ram_rd_data
);

  typedef enum logic [1:0] {DRAIN, IDLE, CMD, WAIT} state_t;

  // cnt is cleared at E0, so at edge En it reads n-1.
  localparam logic [2:0] DRAIN_LAST = 3'(RD_OCC - 2);
  localparam logic [2:0] RD_DONE    = 3'(RD_SMP - 1);
  localparam logic [2:0] RD_LAST    = 3'(RD_OCC - 2);
  localparam logic [2:0] WR_DONE    = 3'(WR_OCC - 3);
  localparam logic [2:0] WR_LAST    = 3'(WR_OCC - 2);

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic          we_reg, we_next;
  logic          owner_reg, owner_next;
  logic          done0_reg, done0_next;
  logic          done1_reg, done1_next;
  logic [DW-1:0] rdata0_reg, rdata0_next;
  logic [DW-1:0] rdata1_reg, rdata1_next;
  logic          rd_reg, rd_next;
  logic          wr_reg, wr_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [DW-1:0] wr_data_reg, wr_data_next;

  logic          any_req;
  logic          win;
  logic          arb_en;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign any_req = req0 | req1;

`ifdef RAM_ARB_RR_EN
  // rr_ptr_reg names the requester that wins the next contended grant.
  logic rr_ptr_reg, rr_ptr_next;

  assign win = (req0 && req1) ? rr_ptr_reg : req1;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (arb_en && any_req) rr_ptr_next = ~win;
  end

  always_ff @(posedge Clk) begin
    if (Rst) rr_ptr_reg <= 1'b0;
    else     rr_ptr_reg <= rr_ptr_next;
  end
`else
  assign win = ~req0;
`endif

  assign sel_we    = win ? we1    : we0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    we_next      = we_reg;
    owner_next   = owner_reg;
    done0_next   = 1'b0;
    done1_next   = 1'b0;
    rdata0_next  = rdata0_reg;
    rdata1_next  = rdata1_reg;
    rd_next      = 1'b0;
    wr_next      = 1'b0;
    rd_addr_next = rd_addr_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    arb_en       = 1'b0;

    case (state_reg)
      DRAIN: begin
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == DRAIN_LAST) state_next = IDLE;
      end
      IDLE: arb_en = 1'b1;
      CMD: begin
        cnt_next   = 3'd0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg + 3'd1;
        if (we_reg ? (cnt_reg == WR_DONE) : (cnt_reg == RD_DONE)) begin
          done0_next = ~owner_reg;
          done1_next = owner_reg;
          if (!we_reg) begin
            if (owner_reg) rdata1_next = ram_rd_data;
            else           rdata0_next = ram_rd_data;
          end
        end
        // The last occupancy edge doubles as an idle edge so the RAM is reissued without a gap.
        if (cnt_reg == (we_reg ? WR_LAST : RD_LAST)) begin
          state_next = IDLE;
          arb_en     = 1'b1;
        end
      end
      default: state_next = DRAIN;
    endcase

    if (arb_en && any_req) begin
      state_next = CMD;
      owner_next = win;
      we_next    = sel_we;
      if (sel_we) begin
        wr_next      = 1'b1;
        wr_addr_next = sel_addr;
        wr_data_next = sel_wdata;
      end else begin
        rd_next      = 1'b1;
        rd_addr_next = sel_addr;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= DRAIN;
      cnt_reg     <= 3'd0;
      we_reg      <= 1'b0;
      owner_reg   <= 1'b0;
      done0_reg   <= 1'b0;
      done1_reg   <= 1'b0;
      rdata0_reg  <= '0;
      rdata1_reg  <= '0;
      rd_reg      <= 1'b0;
      wr_reg      <= 1'b0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      we_reg      <= we_next;
      owner_reg   <= owner_next;
      done0_reg   <= done0_next;
      done1_reg   <= done1_next;
      rdata0_reg  <= rdata0_next;
      rdata1_reg  <= rdata1_next;
      rd_reg      <= rd_next;
      wr_reg      <= wr_next;
      rd_addr_reg <= rd_addr_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign done0       = done0_reg;
  assign done1       = done1_reg;
  assign rdata0      = rdata0_reg;
  assign rdata1      = rdata1_reg;
  assign ram_rd      = rd_reg;
  assign ram_wr      = wr_reg;
  assign ram_rd_addr = rd_addr_reg;
  assign ram_wr_addr = wr_addr_reg;
  assign ram_wr_data = wr_data_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter with a behavioural multi-cycle RAM.
// Expected grant order in the contention test follows RAM_ARB_RR_EN.
module tb_ram_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       ram_rd, ram_wr;
  logic [7:0] ram_rd_addr, ram_wr_addr, ram_wr_data;
  logic [7:0] ram_rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int next_free = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  ram_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  // RAM: command sampled at E0, write commits at E2, read data only valid for the E3 sample.
  logic [7:0] mem [256];
  bit         mem_init = 1'b0;
  int         rd_t = 15;
  int         wr_t = 15;
  logic [7:0] rd_a = '0, wr_a = '0, wr_d = '0;

  always @(posedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(255 - i);
      mem_init <= 1'b1;
    end else if (wr_t == 1) begin
      mem[wr_a] <= wr_d;
    end
    if (ram_rd) begin rd_t <= 0; rd_a <= ram_rd_addr; end
    else if (rd_t < 15) rd_t <= rd_t + 1;
    if (ram_wr) begin wr_t <= 0; wr_a <= ram_wr_addr; wr_d <= ram_wr_data; end
    else if (wr_t < 15) wr_t <= wr_t + 1;
  end

  // Outside the read window the floating bus is modelled as corrupted data.
  assign ram_rd_data = (rd_t == 2) ? mem[rd_a] : (mem[rd_a] ^ 8'h5A);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each command is seen here one half-cycle before its E0 edge.
  always @(negedge Clk) begin
    if (ram_rd | ram_wr) begin
      check("rd_wr_excl", int'(ram_rd & ram_wr), 0);
      check("ram_idle", int'(cyc + 1 >= next_free), 1);
      next_free = cyc + 1 + (ram_rd ? 5 : 4);
    end
  end

  logic [7:0] ref_mem [256];

  task automatic drive(input int port, input bit r, input bit w, input logic [7:0] a,
                       input logic [7:0] d);
    if (port == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else           begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic run_txn(input int port, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input bit hold, output int g_cyc);
    bit got_g = 1'b0;
    bit got_d = 1'b0;
    int d_cyc = -1;
    g_cyc = -1;
    drive(port, 1'b1, w, a, d);
    for (int i = 0; i < 60 && !got_d; i++) begin
      @(negedge Clk);
      if (!got_g && (ram_rd | ram_wr)) begin got_g = 1'b1; g_cyc = cyc; end
      if ((port == 0) ? done0 : done1) begin got_d = 1'b1; d_cyc = cyc; end
    end
    check("done_seen", int'(got_d), 1);
    check(w ? "wr_done_lat" : "rd_done_lat", d_cyc - g_cyc, w ? 3 : 4);
    if (w) ref_mem[a] = d;
    else   check("rdata", int'((port == 0) ? rdata0 : rdata1), int'(exp_rd));
    $display("txn port=%0d we=%0d addr=%0d wdata=%0d rdata=%0d grant=%0d done=%0d",
             port, w, a, d, (port == 0) ? rdata0 : rdata1, g_cyc, d_cyc);
    if (!hold) drive(port, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  int g, g1, g2, rel, n, prev, dport;
  int exp_port [4];
  int ndone;
  bit active [2];
  bit p_we [2];
  logic [7:0] p_addr [2], p_wdata [2];
  logic dn;
  logic [7:0] rd;

  initial begin
`ifdef RAM_ARB_RR_EN
    exp_port = '{0, 1, 0, 1};
`else
    exp_port = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(255 - i);
    Rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(negedge Clk);

    // Reset state, with a read pending while reset is still high.
    drive(0, 1'b1, 1'b0, 8'd73, 8'd0);
    @(negedge Clk);
    check("rst_done0", int'(done0), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_ram_rd", int'(ram_rd), 0);
    check("rst_ram_wr", int'(ram_wr), 0);
    check("rst_rd_addr", int'(ram_rd_addr), 0);
    check("rst_wr_addr", int'(ram_wr_addr), 0);
    check("rst_wr_data", int'(ram_wr_data), 0);
    check("rst_rdata0", int'(rdata0), 0);
    check("rst_rdata1", int'(rdata1), 0);
    Rst = 1'b0;
    rel = cyc;
    run_txn(0, 1'b0, 8'd73, 8'd0, 8'd182, 1'b0, g);
    check("drain_lat", g - rel, 5);
    check("rd_addr", int'(ram_rd_addr), 73);

    // Write then read back on port 1, back to back.
    run_txn(1, 1'b1, 8'd73, 8'd21, 8'd0, 1'b1, g1);
    check("wr_addr", int'(ram_wr_addr), 73);
    check("wr_data", int'(ram_wr_data), 21);
    run_txn(1, 1'b0, 8'd73, 8'd0, 8'd21, 1'b0, g2);
    check("wr_rd_spacing", g2 - g1, 4);

    // Continuous contention: both ports reading.
    drive(0, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b1, 1'b0, 8'd255, 8'd0);
    n = 0;
    prev = -1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge Clk);
      if (done0 | done1) begin
        check("done_onehot", int'(done0 & done1), 0);
        dport = done1 ? 1 : 0;
        check("grant_order", dport, exp_port[n]);
        if (dport == 0) check("rdata0_contend", int'(rdata0), 255);
        else            check("rdata1_contend", int'(rdata1), 0);
        if (prev >= 0) check("contend_spacing", cyc - prev, 5);
        $display("txn contend port=%0d done=%0d", dport, cyc);
        prev = cyc;
        n++;
      end
    end
    check("contend_count", n, 4);
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge Clk);

    // Reset during the WAIT of a read aborts it; the still-held request is reissued.
    drive(0, 1'b1, 1'b0, 8'd10, 8'd0);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge Clk);
      if (ram_rd) n = 1;
    end
    check("abort_grant_seen", n, 1);
    repeat (2) begin
      @(negedge Clk);
      check("abort_wait_done", int'(done0), 0);
    end
    Rst = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("abort_rst_done", int'(done0), 0);
    end
    Rst = 1'b0;
    rel = cyc;
    check("abort_rdata0_rst", int'(rdata0), 0);
    run_txn(0, 1'b0, 8'd10, 8'd0, 8'd245, 1'b0, g);
    check("abort_drain_lat", g - rel, 5);

    // Randomized traffic from both ports, scored against a reference memory.
    ndone = 0;
    active = '{1'b0, 1'b0};
    for (int i = 0; i < 8000 && ndone < 200; i++) begin
      @(negedge Clk);
      for (int p = 0; p < 2; p++) begin
        dn = (p == 0) ? done0 : done1;
        rd = (p == 0) ? rdata0 : rdata1;
        if (dn && active[p]) begin
          if (p_we[p]) ref_mem[p_addr[p]] = p_wdata[p];
          else         check("rnd_rdata", int'(rd), int'(ref_mem[p_addr[p]]));
          $display("txn rnd port=%0d we=%0d addr=%0d wdata=%0d rdata=%0d done=%0d",
                   p, p_we[p], p_addr[p], p_wdata[p], rd, cyc);
          ndone++;
          active[p] = 1'b0;
          drive(p, 1'b0, 1'b0, 8'd0, 8'd0);
        end
        if (!active[p] && ($urandom_range(0, 1) == 1)) begin
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 8'($urandom_range(0, 7));
          p_wdata[p] = 8'($urandom_range(0, 255));
          active[p]  = 1'b1;
          drive(p, 1'b1, p_we[p], p_addr[p], p_wdata[p]);
        end
      end
    end
    check("rnd_count", int'(ndone >= 200), 1);
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (8) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the shared 256x8 multi-cycle RAM. Accepts read/write transactions from two requesters, grants one at a time, and drives the RAM's `rd`/`wr` strobes, addresses and write data. It also observes the RAM's fixed occupancy: 5 cycles per read and 4 per write. It returns read data and a completion pulse to the winning requester, so no requester needs to know the RAM's internal timing.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `RD_SMP`, 3, cycles from RAM command-sample edge (E0) to read-data sample edge
- `RD_OCC`, 5, RAM occupancy of a read, in cycles from E0
- `WR_OCC`, 4, RAM occupancy of a write, in cycles from E0

Ports:
- `Clk` in 1: clock, all logic on posedge
- `Rst` in 1: synchronous, active-high reset
- `req0`, `req1` in 1: transaction request, held until `done`
- `we0`, `we1` in 1: 1 = write, 0 = read
- `addr0`, `addr1` in AW: transaction address
- `wdata0`, `wdata1` in DW: write data
- `done0`, `done1` out 1: one-cycle completion pulse
- `rdata0`, `rdata1` out DW: read result, valid from `done` and held until the next read completes on that port
- `ram_rd`, `ram_wr` out 1: RAM strobes, registered
- `ram_rd_addr`, `ram_wr_addr` out AW: RAM addresses, registered
- `ram_wr_data` out DW: RAM write data, registered
- `ram_rd_data` in DW: RAM read data; high impedance outside the read window

## Operation
- FSM states:
  - `DRAIN`: post-reset hold-off
  - `IDLE`
  - `CMD`: strobe cycle
  - `WAIT`: counting RAM occupancy
- One 3-bit counter `cnt` serves both `DRAIN` and `WAIT`.
- `IDLE`: on an edge where any `req` is high:
  - pick the winner;
  - latch its `we`, `addr`, `wdata`;
  - drive `ram_rd` or `ram_wr` = 1 and the matching address (plus `ram_wr_data` for writes);
  - go to `CMD`.
- `CMD`: lasts exactly one cycle. Deassert the strobe, clear `cnt`, go to `WAIT`. The RAM samples the command at this edge (E0).
- `WAIT`, read:
  - at `cnt == RD_SMP-1` (edge E3), register `ram_rd_data` into `rdataN` and pulse `doneN`;
  - at `cnt == RD_OCC-2` (edge E4), return to `IDLE`.
- `WAIT`, write:
  - the RAM commits at E2; pulse `doneN` at E2;
  - at `cnt == WR_OCC-2` (edge E3), return to `IDLE`.
- `ram_rd` and `ram_wr` are never high together. The RAM gives write priority if both are asserted, so this is a hard invariant.
- Arbitration: see Configuration.
- A `req` dropped before its grant is ignored. A `req` still high in the cycle after its `done` counts as a new transaction.
- Inputs of a non-granted requester are not sampled.

## Timing
- Let G be the grant edge. The strobe is high during cycle G..G+1, and E0 = G+1.
- Read: `done`/`rdata` are updated at G+4. The earliest next grant is G+5, so its E0 is G+6 = old E0 + 5 (RAM idle).
- Write: `done` at G+3. The earliest next grant is G+4, so back-to-back writes are spaced 4 cycles apart.
- Both requesters asserting continuously yields alternating grants (round-robin build) at the spacing above.
- Reset values:
  - all `done`, `ram_rd`, `ram_wr` = 0;
  - all addresses, data and `rdata` = 0;
  - RR pointer = requester 0.
- Reset sends the FSM to `DRAIN`.
- `DRAIN`: the RAM has no reset and may be mid-transaction. The arbiter waits RD_OCC cycles after `Rst` deasserts before the first grant, so the first possible grant edge is the 5th edge after release.
- `Rst` during `CMD`/`WAIT` aborts the transaction: no `done` is issued and the requester must re-request.
- Simultaneous `req` and `Rst`: reset wins.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin.
  - On contention, grant the requester not served last.
  - The pointer updates on each grant.
- `RAM_ARB_RR_EN` undefined: fixed priority.
  - Requester 0 always wins contention; requester 1 may starve.
  - No pointer register.

## Test plan
- Reset, then `req0`=1, `we0`=0, `addr0`=73 → `ram_rd` high 1 cycle; `done0` at G+4; `rdata0`=182.
- `req1` write `addr1`=73, `wdata1`=21, then `req1` read addr 73 → `done1` at G+3 for the write; grant spacing 4; read returns 21.
- Both requesters read (addr 0 and 255) continuously, RR build → grants alternate 0,1,0,1; spacing 5; `rdata0`=255, `rdata1`=0. Non-RR build → only requester 0 granted.
- `Rst` pulsed while in `WAIT` of a read → no `done`. After release, no strobe for 5 cycles, then the pending `req` is granted.
- Randomized pair over 200 transactions → `ram_rd`&`ram_wr` never both 1. No command is issued while the RAM is busy (model check against occupancy).
